// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with a per-register scoreboard.
//
// Each register has a busy bit. An issue sets the bit, a writeback clears it,
// and a flush clears every bit. Reads are combinational and can optionally
// forward same-cycle writeback data. busy_cnt tracks the number of busy
// registers.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears data, busy bits, count)
//   we         writeback enable; waddr/wdata give the target and the value
//   iss_valid  issue strobe; marks iss_addr as having a pending write
//   flush      synchronous clear of all busy bits (register data is kept)
//   raddr      packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata      packed read data, port k at [k*DATA_W +: DATA_W]
//   rbusy      per-port pending-write flag for the addressed register
//   busy_cnt   registered count of busy registers
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we_eff, iss_eff, cnt_set, cnt_clr;
  logic [ADDR_W-1:0] ra;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Writes and issues to the hard-wired zero register are dropped here.
  assign we_eff  = we && !is_zero(waddr);
  assign iss_eff = iss_valid && !is_zero(iss_addr);

  // Register data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_eff) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Busy bits: writeback clears, then issue sets (newer issue wins), flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (we_eff)  busy_d[waddr]    = 1'b0;
    if (iss_eff) busy_d[iss_addr] = 1'b1;
    if (flush)   busy_d           = '0;
  end

  // Count bookkeeping mirrors the busy_d update: a set only counts on an idle
  // register, a clear only counts on a busy one that is not re-issued this cycle.
  always_comb begin
    cnt_set = iss_eff && !busy_q[iss_addr];
    cnt_clr = we_eff && busy_q[waddr] && !(iss_eff && (iss_addr == waddr));
    if (flush) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{ADDR_W{1'b0}}, cnt_set} - {{ADDR_W{1'b0}}, cnt_clr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  // Read ports. Forwarding is suppressed while in reset so outputs read 0.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = raddr[k*ADDR_W +: ADDR_W];
      if (!is_zero(ra)) begin
        rdata[k*DATA_W +: DATA_W] = mem_q[ra];
        rbusy[k]                  = busy_q[ra];
        if ((BYPASS != 0) && we_eff && !rst && (waddr == ra)) begin
          rdata[k*DATA_W +: DATA_W] = wdata;
          rbusy[k]                  = 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, when 1 register 0 reads as 0 and ignores writes.
REQ-005 Parameter BYPASS, default 1, when 1 same-cycle writeback data is forwarded to read ports.
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 we  in  1  writeback enable.
REQ-009 waddr  in  ADDR_W  writeback address.
REQ-010 wdata  in  DATA_W  writeback data.
REQ-011 iss_valid  in  1  issue strobe: mark iss_addr as pending-write (busy).
REQ-012 iss_addr  in  ADDR_W  destination register of issued instruction.
REQ-013 flush  in  1  synchronous clear of all busy bits; register data kept.
REQ-014 raddr  in  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-015 rdata  out  NUM_RD*DATA_W  packed read data, port k at bits [k*DATA_W +: DATA_W].
REQ-016 rbusy  out  NUM_RD  per-port flag: addressed register has a pending write.
REQ-017 busy_cnt  out  ADDR_W+1  number of registers currently marked busy.

Function
REQ-018 Reads are combinational from array state; rdata for port k is mem[raddr_k].
REQ-019 Write: when we=1, mem[waddr] <= wdata on the rising edge; one-cycle write latency.
REQ-020 ZERO_REG=1: writes and issues to address 0 are dropped; reads of 0 return 0; rbusy for address 0 is always 0.
REQ-021 BYPASS=1: if we=1 and waddr==raddr_k (and not the dropped zero register), rdata_k = wdata and rbusy_k = 0 in the same cycle.
REQ-022 BYPASS=0: rdata_k shows old mem contents until the edge; rbusy_k reflects the registered busy bit only.
REQ-023 Busy bit per register: set on edge when iss_valid=1 for iss_addr; cleared on edge when we=1 for waddr.
REQ-024 Issue and writeback to the same address in the same cycle: busy bit ends 1 (newer issue wins); data still written.
REQ-025 Issue to an already-busy register: bit stays 1, no error, no count change.
REQ-026 Writeback to a non-busy register: data written, busy unchanged (stays 0).
REQ-027 flush=1: all busy bits cleared on the edge, overriding same-cycle issue; same-cycle write still updates data.
REQ-028 busy_cnt is a registered count equal to popcount of busy bits after each edge; maintained by increment/decrement, never wraps (max DEPTH, or DEPTH-1 when ZERO_REG=1).
REQ-029 Multiple read ports addressing the same register return identical data and busy.
REQ-030 Out-of-range conditions cannot occur (full address decode); no X on outputs after reset.

Reset
REQ-031 rst=1 asynchronously forces all registers to 0, all busy bits to 0, busy_cnt to 0.
REQ-032 While rst=1, writes, issues and flush are ignored; rdata reads 0 on all ports, rbusy=0.
REQ-033 Reset asserted mid-operation (pending writes outstanding) discards all pending state; first edge after deassert operates normally.

Verification
REQ-034 Reset, then we=1 waddr=3 wdata=0xDEADBEEF; next cycle raddr0=3 -> rdata0=0xDEADBEEF, rbusy0=0.
REQ-035 we=1 waddr=0 wdata=0x1234, iss_valid=1 iss_addr=0 -> read addr 0 gives 0, rbusy=0, busy_cnt=0.
REQ-036 iss_valid addr 5 (busy_cnt->1, rbusy for addr 5 =1); later we=1 waddr=5 wdata=0x55 with raddr1=5 same cycle -> BYPASS=1: rdata1=0x55, rbusy1=0; after edge busy_cnt=0.
REQ-037 Same cycle iss_valid addr 7 and we addr 7 wdata=0x77 -> after edge mem[7]=0x77, busy[7]=1, busy_cnt unchanged if previously busy else +1.
REQ-038 Issue addrs 1,2,3 (busy_cnt=3), then flush=1 with iss_valid addr 4 -> busy_cnt=0, all rbusy=0.
REQ-039 Write regs 1..31 with nonzero values and issue 6, assert rst for half a cycle asynchronously -> immediately all rdata=0, rbusy=0, busy_cnt=0.
